ps2_kbd_decoder: RTL and testbench

Receives PS/2 set-2 scan-code frames from the keyboard pins and drives the `kbd_ascii`/`state` pair consumed by the game core's keyboard capture logic. It deserialises 11-bit frames and checks start, odd parity and stop. It tracks make/break/extended prefixes and maps letter, digit, space and enter keys to ASCII. It sits between the board PS/2 connector and the game top level, in the `clk` (50 MHz) domain.

---
 rtl/ps2_kbd_decoder.sv | 189 ++++++++++++++++++
 tb/tb_ps2_kbd_decoder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_decoder.sv
// PS/2 set-2 keyboard receiver: pin sync, 11-bit frame capture with
// start/odd-parity/stop checking and timeout, then make/break/extended
// tracking and scan-code to ASCII mapping for letters, digits, space, enter.
module ps2_kbd_decoder #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kbd_ascii,
    output logic [1:0] state,
    output logic       key_event,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } rx_state_t;

    logic [1:0]  r_clk_sync;
    logic [1:0]  r_dat_sync;
    logic        r_clk_prev;
    logic        w_fall;
    logic        w_dat;

    rx_state_t   r_rx;
    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par;
    logic        r_stop;
    logic [TW-1:0] r_tcnt;
    logic        r_dec_vld;
    logic [7:0]  r_dec_byte;

    logic        r_brk;
    logic        r_ext;
    logic [7:0]  r_held;

    // Set-2 make code to ASCII; zero means the key is not mapped.
    function automatic logic [7:0] f_map(input logic [7:0] code);
        case (code)
            8'h1C: f_map = 8'h61;  8'h32: f_map = 8'h62;  8'h21: f_map = 8'h63;
            8'h23: f_map = 8'h64;  8'h24: f_map = 8'h65;  8'h2B: f_map = 8'h66;
            8'h34: f_map = 8'h67;  8'h33: f_map = 8'h68;  8'h43: f_map = 8'h69;
            8'h3B: f_map = 8'h6A;  8'h42: f_map = 8'h6B;  8'h4B: f_map = 8'h6C;
            8'h3A: f_map = 8'h6D;  8'h31: f_map = 8'h6E;  8'h44: f_map = 8'h6F;
            8'h4D: f_map = 8'h70;  8'h15: f_map = 8'h71;  8'h2D: f_map = 8'h72;
            8'h1B: f_map = 8'h73;  8'h2C: f_map = 8'h74;  8'h3C: f_map = 8'h75;
            8'h2A: f_map = 8'h76;  8'h1D: f_map = 8'h77;  8'h22: f_map = 8'h78;
            8'h35: f_map = 8'h79;  8'h1A: f_map = 8'h7A;
            8'h45: f_map = 8'h30;  8'h16: f_map = 8'h31;  8'h1E: f_map = 8'h32;
            8'h26: f_map = 8'h33;  8'h25: f_map = 8'h34;  8'h2E: f_map = 8'h35;
            8'h36: f_map = 8'h36;  8'h3D: f_map = 8'h37;  8'h3E: f_map = 8'h38;
            8'h46: f_map = 8'h39;
            8'h29: f_map = 8'h20;  8'h5A: f_map = 8'h0D;
            default: f_map = 8'h00;
        endcase
    endfunction

    // Two-flop synchronisers on both pins plus a history flop on the clock pin.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync <= 2'b00;
            r_dat_sync <= 2'b00;
            r_clk_prev <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};
            r_clk_prev <= r_clk_sync[1];
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync[1];
    assign w_dat  = r_dat_sync[1];

    // Frame receiver: start bit, 8 data bits LSB first, parity, stop, check.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx       <= S_IDLE;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
            r_par      <= 1'b0;
            r_stop     <= 1'b0;
            r_tcnt     <= '0;
            r_dec_vld  <= 1'b0;
            r_dec_byte <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            r_dec_vld <= 1'b0;
            if (w_fall)
                r_tcnt <= '0;
            case (r_rx)
                S_IDLE: begin
                    if (w_fall) begin
                        if (!w_dat) begin
                            r_rx      <= S_SHIFT;
                            r_bit_cnt <= 4'd1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_fall) begin
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt <= 4'd8)
                            r_shift <= {w_dat, r_shift[7:1]};
                        else if (r_bit_cnt == 4'd9)
                            r_par <= w_dat;
                        else begin
                            r_stop <= w_dat;
                            r_rx   <= S_CHECK;
                        end
                    end else if (r_tcnt == TW'(TIMEOUT_CYCLES)) begin
                        frame_err <= 1'b1;
                        r_rx      <= S_IDLE;
                        r_bit_cnt <= 4'd0;
                        r_tcnt    <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if ((^{r_shift, r_par}) && r_stop) begin
                        r_dec_vld  <= 1'b1;
                        r_dec_byte <= r_shift;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    r_rx      <= S_IDLE;
                    r_bit_cnt <= 4'd0;
                end
                default: begin
                    r_rx      <= S_IDLE;
                    r_bit_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Decoder: prefix flags, latest-key tracking and ASCII/state outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_held    <= 8'h00;
            kbd_ascii <= 8'h00;
            state     <= 2'b00;
            scan_code <= 8'h00;
            key_event <= 1'b0;
        end else begin
            key_event <= 1'b0;
            if (r_dec_vld) begin
                if (r_dec_byte == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_dec_byte == 8'hF0) begin
                    r_brk <= 1'b1;
                end else begin
                    scan_code <= r_dec_byte;
                    if (r_ext) begin
                        // Extended keys (arrows etc.) are not tracked at all.
                        r_ext <= 1'b0;
                        r_brk <= 1'b0;
                    end else if (!r_brk) begin
                        // Typematic repeats of the held key leave outputs alone.
                        if ((r_dec_byte != r_held) || (state == 2'b00)) begin
                            r_held    <= r_dec_byte;
                            kbd_ascii <= f_map(r_dec_byte);
                            state     <= (f_map(r_dec_byte) != 8'h00) ? 2'b01 : 2'b11;
                            key_event <= 1'b1;
                        end
                    end else begin
                        if (r_dec_byte == r_held)
                            state <= 2'b00;
                        r_brk <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Randomised scoreboard bench for ps2_kbd_decoder: a key-table reference
// model predicts key_event/frame_err pulses and the output registers.
module tb_ps2_kbd_decoder;

    localparam int TMO  = 50000;
    localparam int HALF = 8;
    localparam int GAP  = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] kbd_ascii;
    logic [1:0] state;
    logic       key_event;
    logic [7:0] scan_code;
    logic       frame_err;

    ps2_kbd_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kbd_ascii(kbd_ascii), .state(state), .key_event(key_event),
        .scan_code(scan_code), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_fall_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] ascii;
        logic [1:0] st;
        logic [7:0] sc;
    } exp_t;
    exp_t q[$];

    // Reference model state, expressed directly as keyboard semantics.
    logic [7:0] m_ascii, m_sc, m_held;
    logic [1:0] m_st;
    bit         m_brk, m_ext;

    logic [7:0] letter_code [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
        8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_code [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
        8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] unmapped [4] = '{8'h76, 8'h05, 8'h0E, 8'h66};

    function automatic logic [7:0] ref_ascii(input logic [7:0] c);
        for (int i = 0; i < 26; i++) if (letter_code[i] == c) return 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) if (digit_code[i] == c) return 8'h30 + 8'(i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ascii = 8'h00; m_sc = 8'h00; m_held = 8'h00; m_st = 2'b00;
        m_brk = 0; m_ext = 0;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1; e.ascii = 0; e.st = 0; e.sc = 0;
        q.push_back(e);
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            m_sc = b;
            if (m_ext) begin
                m_ext = 0; m_brk = 0;
            end else if (!m_brk) begin
                if (b != m_held || m_st == 2'b00) begin
                    m_held  = b;
                    m_ascii = ref_ascii(b);
                    m_st    = (m_ascii != 0) ? 2'b01 : 2'b11;
                    e.is_err = 0; e.ascii = m_ascii; e.st = m_st; e.sc = b;
                    q.push_back(e);
                end
            end else begin
                if (b == m_held) m_st = 2'b00;
                m_brk = 0;
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        if (bad_par || bad_stop) push_err();
        else model_byte(b);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    // Start bit plus (n-1) data bits, then leave the line idle-high clocked.
    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = (i == 0) ? 1'b0 : 1'b1;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ascii"}, 32'(kbd_ascii), 32'(m_ascii));
        chk({tag, ".state"}, 32'(state), 32'(m_st));
        chk({tag, ".scan"}, 32'(scan_code), 32'(m_sc));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".ascii0"}, 32'(kbd_ascii), 32'h0);
        chk({tag, ".state0"}, 32'(state), 32'h0);
        chk({tag, ".scan0"}, 32'(scan_code), 32'h0);
        chk({tag, ".kev0"}, 32'(key_event), 32'h0);
        chk({tag, ".ferr0"}, 32'(frame_err), 32'h0);
    endtask

    // Monitor: every output pulse must match the next predicted event.
    always @(negedge clk) begin
        if (!reset) begin
            if (key_event && frame_err) chk("pulse_overlap", 32'd1, 32'd0);
            if (key_event || frame_err) begin
                if (q.size() == 0) begin
                    chk("unexpected_pulse", {30'd0, key_event, frame_err}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_kind", 32'(frame_err), 32'(e.is_err));
                    if (!e.is_err && key_event) begin
                        chk("kev.ascii", 32'(kbd_ascii), 32'(e.ascii));
                        chk("kev.state", 32'(state), 32'(e.st));
                        chk("kev.scan", 32'(scan_code), 32'(e.sc));
                        chk("kev.latency", 32'(cyc - last_fall_cyc), 32'd5);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b;
        int r;
        model_reset();
        repeat (4) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_frame(8'h1C, 0, 0);              check_outputs("make_a");
        send_frame(8'h1C, 0, 0); send_frame(8'h1C, 0, 0); send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0); check_outputs("typematic_break");
        send_frame(8'h1C, 0, 0); send_frame(8'h32, 0, 0);
        send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0); check_outputs("latest_key");
        chk("latest_key.state_held", 32'(state), 32'd1);
        send_frame(8'hF0, 0, 0); send_frame(8'h32, 0, 0); check_outputs("break_b");
        send_frame(8'hE0, 0, 0); send_frame(8'h75, 0, 0);
        send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
        check_outputs("extended");
        chk("extended.scan75", 32'(scan_code), 32'h75);
        send_frame(8'h1C, 1, 0);              check_outputs("bad_parity");
        send_frame(8'h32, 0, 1);              check_outputs("bad_stop");

        // Start bit of 1 while idle.
        push_err();
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (GAP) @(negedge clk);
        check_outputs("bad_start");

        // Stall three edges into a frame.
        push_err();
        send_partial(3);
        repeat (TMO + 100) @(negedge clk);
        chk("timeout.pending", 32'(q.size()), 32'd0);
        send_frame(8'h29, 0, 0);              check_outputs("after_timeout");
        chk("after_timeout.space", 32'(kbd_ascii), 32'h20);

        send_frame(8'h76, 0, 0);              check_outputs("esc");
        chk("esc.state11", 32'(state), 32'h3);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            if (r < 15)      b = 8'hF0;
            else if (r < 22) b = 8'hE0;
            else if (r < 55) b = letter_code[$urandom_range(0, 25)];
            else if (r < 72) b = digit_code[$urandom_range(0, 9)];
            else if (r < 80) b = ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h5A;
            else             b = unmapped[$urandom_range(0, 3)];
            r = $urandom_range(0, 11);
            send_frame(b, r == 0, r == 1);
            check_outputs("rand");
        end

        // Reset during a frame clears everything at once.
        send_frame(8'h76, 0, 0);
        send_partial(4);
        @(negedge clk) ps2_clk = 1'b0;
        #3 reset = 1'b1;
        #1 check_zero("async_reset");
        model_reset();
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 0, 0);              check_outputs("post_reset");

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
